// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: iterative unsigned multu (shift-add) and
// divu (restoring), one bit per cycle, with pipeline stall generation.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [1:0]       opE,
  input  logic [1:0]       mfE,
  output logic [WIDTH-1:0] Out,
  output logic             stallE,
  output logic             busy
);
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
  logic             is_div;

  logic             op_req, accept, last;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign op_req = (opE == 2'b01) || (opE == 2'b10);
  assign busy   = (state == RUN);
  assign stallE = busy && (mfE[1] || op_req);
  assign accept = (state == IDLE) && op_req && !stallE;
  assign last   = (state == RUN) && (cnt == CW'(ITERS - 1));

  // HI/LO are only written on completion, so reading them in IDLE is always
  // the committed value (mf + op in the same cycle reads the old value).
  always_comb begin
    Out = '0;
    if (state == IDLE) begin
      case (mfE)
        2'b10:   Out = hi;
        2'b11:   Out = lo;
        default: Out = '0;
      endcase
    end
  end

  // One iteration of either algorithm. Multiply: acc_hi is the running upper
  // half, acc_lo shifts the multiplier out and product bits in. Divide: acc_hi
  // is the partial remainder, acc_lo shifts the dividend out and quotient in.
  // A zero divisor always subtracts nothing, which leaves LO all ones and
  // HI equal to the dividend without a special case.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_trial = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, opnd_b};
    if (is_div) begin
      step_hi = div_ge ? WIDTH'(div_trial - {1'b0, opnd_b}) : div_trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= SrcAE;
      opnd_b <= SrcBE;
      is_div <= opE[1];
    end else if (state == RUN) begin
      cnt    <= cnt + 1'b1;
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last) begin
        hi <= step_hi;
        lo <= step_lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed plus random instructions,
// HI/LO and busy timing predicted from plain arithmetic and a cycle count.
module tb_hilo_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] SrcAE = '0, SrcBE = '0;
  logic [1:0]   opE = 2'b00, mfE = 2'b00;
  logic [W-1:0] Out;
  logic         stallE, busy;

  hilo_muldiv_ctrl #(.WIDTH(W), .ITERS(W)) dut (
    .clk(clk), .rst_n(rst_n), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .opE(opE), .mfE(mfE), .Out(Out), .stallE(stallE), .busy(busy)
  );

  always #5 clk = ~clk;

  int           checks = 0, errors = 0;
  int           cyc = 0, acc_cyc = 0;
  bit           m_active = 1'b0, mon_en = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] exp_q[$];
  logic         eb, es;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // An accepted op occupies the unit for exactly W cycles.
  function automatic bit model_busy();
    return m_active && ((cyc - acc_cyc) < W);
  endfunction

  function automatic bit model_stall();
    return model_busy() && (mfE[1] || opE == 2'b01 || opE == 2'b10);
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (op == 2'b01) begin
      p = (2*W)'(a) * (2*W)'(b);
      m_hi = p[2*W-1:W];
      m_lo = p[W-1:0];
    end else if (b == '0) begin
      m_hi = a;
      m_lo = '1;
    end else begin
      m_hi = a % b;
      m_lo = a / b;
    end
  endtask

  // Drive one instruction, hold it while the model says it is stalled, and
  // return just after the edge that consumes it.
  task automatic issue(input logic [1:0] op, input logic [1:0] mf,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    opE = op; mfE = mf; SrcAE = a; SrcBE = b;
    if (mf[1]) exp_q.push_back(mf[0] ? m_lo : m_hi);
    @(negedge clk);
    n = 0;
    while (model_stall() && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL stall_timeout got stalled %0d cycles want < 100", n);
    end
    @(posedge clk); #1;
    if (op == 2'b01 || op == 2'b10) begin
      model_apply(op, a, b);
      m_active = 1'b1;
      acc_cyc  = cyc;
    end
    opE = 2'b00; mfE = 2'b00;
    SrcAE = $urandom; SrcBE = $urandom;  // must not disturb captured operands
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      eb = model_busy();
      es = model_stall();
      chk("busy", W'(busy), W'(eb));
      chk("stallE", W'(stallE), W'(es));
      if (eb) chk("out_run", Out, '0);
      else if (mfE[1]) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mf_unexpected got %h want no read", Out);
        end else chk(mfE[0] ? "mflo" : "mfhi", Out, exp_q.pop_front());
      end else chk("out_idle", Out, '0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rop, rmf;
    logic [W-1:0] ra, rb;

    mfE = 2'b11;
    #3;
    chk("rst_out", Out, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_stall", W'(stallE), '0);
    mfE = 2'b00;
    #17 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(2'b10, 2'b00, 32'd100, 32'd7);
    issue(2'b00, 2'b10, '0, '0);
    issue(2'b00, 2'b11, '0, '0);
    issue(2'b01, 2'b00, 32'hFFFF_FFFF, 32'd2);
    issue(2'b00, 2'b10, '0, '0);
    issue(2'b00, 2'b11, '0, '0);
    issue(2'b10, 2'b00, 32'd10, 32'd3);
    issue(2'b00, 2'b00, '0, '0);
    issue(2'b00, 2'b11, '0, '0);
    issue(2'b00, 2'b10, '0, '0);
    issue(2'b10, 2'b00, 32'h1234, 32'd0);
    issue(2'b00, 2'b11, '0, '0);
    issue(2'b00, 2'b10, '0, '0);
    issue(2'b01, 2'b00, 32'd3, 32'd5);
    issue(2'b10, 2'b00, 32'd9, 32'd2);
    issue(2'b00, 2'b11, '0, '0);
    issue(2'b00, 2'b10, '0, '0);
    issue(2'b01, 2'b11, 32'd7, 32'd6);  // reads old LO, starts new op
    issue(2'b11, 2'b01, '0, '0);        // reserved op / plain: never stalls
    issue(2'b00, 2'b11, '0, '0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      rmf = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      issue(rop, rmf, ra, rb);
      for (int g = $urandom_range(0, 2); g > 0; g--) issue(2'b00, 2'b00, '0, '0);
    end

    issue(2'b01, 2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(2'b10, 2'b00, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    mfE   = 2'b10;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_stall", W'(stallE), '0);
    chk("arst_out", Out, '0);
    m_hi = '0; m_lo = '0; m_active = 1'b0;
    mfE = 2'b00;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 2'b10, '0, '0);
    issue(2'b00, 2'b11, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;

    chk("queue_drained", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for the HI/LO unit in the EX stage of the pipelined MIPS core.
- Owns the HI and LO registers and runs unsigned multiply (shift-add) and unsigned divide (restoring) iteratively, one bit per cycle.
- Stalls the pipeline while a mfhi/mflo or a new mult/div would collide with an operation in flight.
- Replaces the single-cycle combinational divide path.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- ITERS, WIDTH, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SrcAE  input  WIDTH  multiplicand / dividend.
- SrcBE  input  WIDTH  multiplier / divisor.
- opE  input  2  00 none, 01 multu, 10 divu, 11 reserved (treated as none).
- mfE  input  2  00 none, 01 none, 10 mfhi, 11 mflo.
- Out  output  WIDTH  mfhi/mflo result.
- stallE  output  1  hold F/D/E, bubble into M.
- busy  output  1  an operation is in flight.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, HI=0, LO=0, iteration counter=0, internal operand/accumulator registers=0. Outputs while in reset: Out=0, stallE=0, busy=0.
- Reset mid-operation aborts the operation; HI/LO clear to 0, not partial results.
- States are IDLE and RUN.
- IDLE:
  - opE=01/10 and stallE=0 at edge T: capture operands, clear counter, go to RUN.
  - opE=00/11: stay in IDLE.
- RUN:
  - Counter increments each edge. At the edge where the counter reaches ITERS-1, write HI/LO and go to IDLE.
  - Accept at edge T, so results are visible in HI/LO after edge T+ITERS (32 for WIDTH=32).
  - busy=1 exactly in RUN.
- multu: 2*WIDTH product via shift-add. HI = product[2W-1:W], LO = product[W-1:0].
- divu (restoring): LO = quotient, HI = remainder, matching SrcAE/SrcBE and SrcAE%SrcBE.
- Divide by zero: no trap. Result is fixed: LO = all ones, HI = SrcAE.
- Operands are captured at accept. Later changes on SrcAE/SrcBE during RUN have no effect.
- Out is combinational from registered state:
  - mfE=10 gives HI; mfE=11 gives LO; 00/01 give 0.
  - In RUN, Out = 0 and is don't-care to consumers, because stall is asserted.
- stallE is combinational and = busy AND (mfE[1] OR opE in {01,10}).
  - A mf or new op during RUN is held until the cycle after completion.
  - On that cycle the mf reads the new HI/LO.
  - The new op is accepted at that cycle's edge; there is no dead cycle between back-to-back ops.
- mf and op in the same cycle in IDLE: Out returns the old HI/LO and the op is accepted. Read-before-write.
- Plain instructions (opE=00, mfE=0x) never stall during RUN; independent instructions proceed.
- No partial HI/LO update is ever visible. Both are written on the same edge.

Test Plan:
- Reset, then divu SrcAE=100, SrcBE=7 -> busy high 32 cycles; then mfhi Out=2 and mflo Out=14.
- multu 0xFFFFFFFF * 2 -> HI=0x00000001, LO=0xFFFFFFFE after 32 cycles.
- divu 10/3 accepted, mflo issued next cycle -> stallE=1 for 31 cycles; released cycle Out=3; mfhi after gives 1.
- divu 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234, no hang.
- multu 3*5 then divu 9/2 presented during RUN -> second op stalled, accepted on the completion cycle. Final HI=1, LO=4 after 64 cycles total.
- rst_n low at cycle 10 of a divu -> busy=0, stallE=0, HI=LO=0 immediately and asynchronously. mfhi after release gives 0.
